// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage.
// Takes load/store commands from the execute stage, runs a single-port
// data-memory transaction (req/gnt/rvalid), extends load data and hands a
// registered result to writeback. Misaligned accesses and bus timeouts are
// reported as one-cycle pulses.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_ld_ma/cmd_st_ma load / store valid
//   wbk_rd_reg_ma       instruction writes rd
//   rd_adr_ma           destination register
//   rd_data_ma          effective address (ld/st) or ALU result
//   st_data_ma          store data
//   ldst_code_ma        funct3 access size / signedness
//   dmem_*              data-memory bus (req/we/adr/be/wdata out, gnt/rvalid/rdata in)
//   ma_stall            upstream must hold MA inputs
//   wbk_rd_reg_wb, rd_adr_wb, rd_data_wb   registered writeback
//   ldst_misalign, ldst_misalign_adr       misalignment pulse + address
//   dmem_timeout        bus-timeout pulse
module mem_access #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_adr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        ma_stall,
  output logic        wbk_rd_reg_wb,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] rd_data_wb,
  output logic        ldst_misalign,
  output logic [31:0] ldst_misalign_adr,
  output logic        dmem_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [4:0]  cap_rd;
  logic [1:0]  cap_lane;
  logic [2:0]  cap_code;

  logic        is_ldst, misaligned, tmo_hit;
  logic        accept, rd_done, tmo;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign is_ldst = cmd_ld_ma | cmd_st_ma;
  assign tmo_hit = (cnt == TMO_LAST);

  // Access size comes from code[1:0]: 1x is a word (011/110/111 included),
  // 01 a halfword, 00 a byte. Byte enables and lane replication follow it.
  always_comb begin
    misaligned = 1'b0;
    be_nxt     = 4'b1111;
    wdata_nxt  = st_data_ma;
    if (ldst_code_ma[1]) begin
      misaligned = (rd_data_ma[1:0] != 2'b00);
    end else if (ldst_code_ma[0]) begin
      misaligned = rd_data_ma[0];
      be_nxt     = rd_data_ma[1] ? 4'b1100 : 4'b0011;
      wdata_nxt  = {2{st_data_ma[15:0]}};
    end else begin
      be_nxt     = 4'b0001 << rd_data_ma[1:0];
      wdata_nxt  = {4{st_data_ma[7:0]}};
    end
  end

  // Lane select and extension of returned load data using the captured
  // address lane and code; code[2] marks the unsigned variants.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (cap_lane)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = cap_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_code)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // Next-state and stall. A grant beats a timeout in the same cycle, and a
  // store completes on its grant so the stall drops right there.
  always_comb begin
    state_nxt = state;
    ma_stall  = 1'b0;
    accept    = 1'b0;
    rd_done   = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (is_ldst && !misaligned) begin
          accept    = 1'b1;
          ma_stall  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (!dmem_we) begin
            ma_stall  = 1'b1;
            state_nxt = WAIT_RD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tmo_hit) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else begin
          ma_stall = 1'b1;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else begin
          ma_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) ma_stall = 1'b0;
  end

  // State register plus all registered outputs. Pulses and the writeback
  // enable default to 0 each cycle and are raised only by their events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= 8'd0;
      cap_rd            <= 5'd0;
      cap_lane          <= 2'd0;
      cap_code          <= 3'd0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_adr          <= 30'd0;
      dmem_be           <= 4'd0;
      dmem_wdata        <= 32'd0;
      wbk_rd_reg_wb     <= 1'b0;
      rd_adr_wb         <= 5'd0;
      rd_data_wb        <= 32'd0;
      ldst_misalign     <= 1'b0;
      ldst_misalign_adr <= 32'd0;
      dmem_timeout      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= (state == IDLE) ? 8'd0 : cnt + 8'd1;
      wbk_rd_reg_wb <= 1'b0;
      ldst_misalign <= 1'b0;
      dmem_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_ldst) begin
            wbk_rd_reg_wb <= wbk_rd_reg_ma;
            rd_adr_wb     <= rd_adr_ma;
            rd_data_wb    <= rd_data_ma;
          end else if (!accept) begin
            ldst_misalign     <= 1'b1;
            ldst_misalign_adr <= rd_data_ma;
          end else begin
            cap_rd     <= rd_adr_ma;
            cap_lane   <= rd_data_ma[1:0];
            cap_code   <= ldst_code_ma;
            dmem_req   <= 1'b1;
            dmem_we    <= cmd_st_ma;
            dmem_adr   <= rd_data_ma[31:2];
            dmem_be    <= be_nxt;
            dmem_wdata <= wdata_nxt;
          end
        end
        REQ: begin
          if (dmem_gnt || tmo) dmem_req <= 1'b0;
          if (tmo) dmem_timeout <= 1'b1;
        end
        WAIT_RD: begin
          if (rd_done) begin
            wbk_rd_reg_wb <= 1'b1;
            rd_adr_wb     <= cap_rd;
            rd_data_wb    <= ld_ext;
          end
          if (tmo) dmem_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
